// File: rtl/forward_scoreboard_pkg.sv
// Shared types, defaults and width helpers for the forwarding scoreboard.
package fwd_pkg;

  localparam int DEF_REG_AW  = 5;
  localparam int DEF_NUM_SRC = 2;
  localparam int DEF_DEPTH   = 3;
  localparam int DEF_CNT_W   = 16;

  // Entry fields are sized for the widest supported configuration; unused upper bits stay zero.
  localparam int ENT_RD_W  = 16;
  localparam int ENT_CNT_W = 8;

  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [ENT_RD_W-1:0]  rd;
    logic [ENT_CNT_W-1:0] cnt;
  } entry_t;

  function automatic int lat_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [ENT_CNT_W-1:0] age_cnt(input logic [ENT_CNT_W-1:0] cnt);
    return (cnt == '0) ? cnt : cnt - ENT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// Issue/forwarding bus between the issue stage and the forwarding scoreboard.
interface forward_scoreboard_if #(
  parameter int REG_AW  = fwd_pkg::DEF_REG_AW,
  parameter int NUM_SRC = fwd_pkg::DEF_NUM_SRC,
  parameter int DEPTH   = fwd_pkg::DEF_DEPTH,
  parameter int CNT_W   = fwd_pkg::DEF_CNT_W
);
  localparam int LAT_W = fwd_pkg::lat_w(DEPTH);
  localparam int SEL_W = fwd_pkg::sel_w(DEPTH);

  logic                       issue_valid;
  logic                       issue_ready;
  logic                       issue_we;
  logic [REG_AW-1:0]          issue_rd;
  logic [LAT_W-1:0]           issue_lat;
  logic [NUM_SRC-1:0]         src_en;
  logic [NUM_SRC*REG_AW-1:0]  src_reg;
  logic                       flush;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;
  logic [CNT_W-1:0]           stall_cnt;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat, src_en, src_reg, flush,
    input  issue_ready, fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat, src_en, src_reg, flush,
    output issue_ready, fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/forward_scoreboard_match.sv
// Priority compare of one source operand against the in-flight entries.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SEL_W  = 2
) (
  input  entry_t [DEPTH-1:0] i_ent,
  input  logic               i_en,
  input  logic [REG_AW-1:0]  i_reg,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_blocked
);

  logic [ENT_RD_W-1:0] w_reg;
  logic                w_found;

  assign w_reg = ENT_RD_W'(i_reg);

  // Youngest stage first: the first hit decides both the select and the stall,
  // so an older ready copy can never mask a younger unready producer.
  always_comb begin
    o_sel     = SEL_W'(FWD_REGFILE);
    o_blocked = 1'b0;
    w_found   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_found && i_en && i_ent[k].valid && i_ent[k].we &&
          (i_ent[k].rd != '0) && (i_ent[k].rd == w_reg)) begin
        w_found   = 1'b1;
        o_sel     = SEL_W'(k + 1);
        o_blocked = (i_ent[k].cnt != '0);
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks in-flight register writers, picks forwarding sources per operand and
// stalls issue while the youngest producer of an operand is not yet ready.
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst_n,
  forward_scoreboard_if.slave bus
);

  localparam int SEL_W = sel_w(DEPTH);

  entry_t [DEPTH-1:0]   r_ent;
  entry_t [DEPTH-1:0]   w_ent_next;
  entry_t               w_new;
  logic [ENT_CNT_W-1:0] w_lat;
  logic [ENT_CNT_W-1:0] w_lat_cap;
  logic [SEL_W-1:0]     w_sel [NUM_SRC];
  logic                 w_blocked [NUM_SRC];
  logic                 w_stall;
  logic                 w_load;
  logic [CNT_W-1:0]     r_stall_cnt;

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
      ) u_match (
        .i_ent     (r_ent),
        .i_en      (bus.src_en[s]),
        .i_reg     (bus.src_reg[s*REG_AW +: REG_AW]),
        .o_sel     (w_sel[s]),
        .o_blocked (w_blocked[s])
      );
    end
  endgenerate

  always_comb begin
    w_stall = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_stall = w_stall | w_blocked[s];
    end
    w_stall = w_stall & bus.issue_valid;
  end

  always_comb begin
    bus.fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      bus.fwd_sel[s*SEL_W +: SEL_W] = w_sel[s];
    end
  end

  assign bus.stall       = w_stall;
  assign bus.issue_ready = !w_stall;
  assign bus.stall_cnt   = r_stall_cnt;

  // Flush beats a same-cycle issue even when the issue would have been accepted.
  assign w_load    = bus.issue_valid && !w_stall && !bus.flush;
  assign w_lat     = ENT_CNT_W'(bus.issue_lat);
  assign w_lat_cap = ENT_CNT_W'(DEPTH - 1);

  always_comb begin
    w_new = '0;
    if (w_load) begin
      w_new.valid = 1'b1;
      w_new.we    = bus.issue_we;
      w_new.rd    = ENT_RD_W'(bus.issue_rd);
      w_new.cnt   = (w_lat > w_lat_cap) ? w_lat_cap : w_lat;
    end
  end

  always_comb begin
    w_ent_next    = '0;
    w_ent_next[0] = w_new;
    for (int k = 1; k < DEPTH; k++) begin
      w_ent_next[k]     = r_ent[k-1];
      w_ent_next[k].cnt = age_cnt(r_ent[k-1].cnt);
      if ((k == 1) && bus.flush) begin
        w_ent_next[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent <= '0;
    end else begin
      r_ent <= w_ent_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed self-checking bench for forward_scoreboard (DEPTH=3, NUM_SRC=2).
module tb_forward_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  int   nCompared   = 0;
  int   nMismatched = 0;

  always #5 clk = ~clk;

  forward_scoreboard_if #(.REG_AW(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(16)) bus ();

  forward_scoreboard #(.REG_AW(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [1:0] sel0;
  logic [1:0] sel1;
  assign sel0 = bus.fwd_sel[1:0];
  assign sel1 = bus.fwd_sel[3:2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.issue_lat   = 2'd0;
    bus.src_en      = 2'b00;
    bus.src_reg     = 10'd0;
    bus.flush       = 1'b0;
  endtask

  task automatic drain();
    setIdle();
    repeat (3) tick();
  endtask

  task automatic driveIssue(input logic we, input logic [4:0] rd, input logic [1:0] lat);
    setIdle();
    bus.issue_valid = 1'b1;
    bus.issue_we    = we;
    bus.issue_rd    = rd;
    bus.issue_lat   = lat;
  endtask

  // Consumer instructions never write a register, so they never become producers.
  task automatic driveConsumer(input logic [1:0] en, input logic [4:0] r0, input logic [4:0] r1);
    setIdle();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd1;
    bus.src_en      = en;
    bus.src_reg     = {r1, r0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    driveConsumer(2'b01, 5'd8, 5'd0);
    #2;
    nCompared++;
    if (bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_stall: got %0b expected 0", bus.stall); end
    nCompared++;
    if (bus.issue_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready: got %0b expected 1", bus.issue_ready); end
    nCompared++;
    if (sel0 !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_sel0: got %0d expected 0", sel0); end
    nCompared++;
    if (bus.stall_cnt !== 16'd0) begin nMismatched++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.stall_cnt); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    nCompared++;
    if (sel0 !== 2'd0) begin nMismatched++; $display("[TB] FAIL post_reset_sel0: got %0d expected 0", sel0); end
    nCompared++;
    if (bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_stall: got %0b expected 0", bus.stall); end
    drain();
  endtask

  task automatic test_lat0();
    driveIssue(1'b1, 5'd8, 2'd0);
    #1;
    nCompared++;
    if (bus.issue_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL lat0_ready: got %0b expected 1", bus.issue_ready); end
    tick();
    driveConsumer(2'b01, 5'd8, 5'd0);
    #1;
    nCompared++;
    if (sel0 !== 2'd1) begin nMismatched++; $display("[TB] FAIL lat0_sel_stage0: got %0d expected 1", sel0); end
    nCompared++;
    if (bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL lat0_stall: got %0b expected 0", bus.stall); end
    tick();
    #1;
    nCompared++;
    if (sel0 !== 2'd2) begin nMismatched++; $display("[TB] FAIL lat0_sel_stage1: got %0d expected 2", sel0); end
    drain();
  endtask

  task automatic test_load_use();
    driveIssue(1'b1, 5'd9, 2'd1);
    tick();
    driveConsumer(2'b10, 5'd0, 5'd9);
    #1;
    nCompared++;
    if (bus.stall !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_use_stall: got %0b expected 1", bus.stall); end
    nCompared++;
    if (bus.issue_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_use_ready: got %0b expected 0", bus.issue_ready); end
    nCompared++;
    if (sel1 !== 2'd1) begin nMismatched++; $display("[TB] FAIL load_use_sel_wait: got %0d expected 1", sel1); end
    tick();
    #1;
    nCompared++;
    if (bus.stall_cnt !== 16'd1) begin nMismatched++; $display("[TB] FAIL load_use_cnt: got %0d expected 1", bus.stall_cnt); end
    nCompared++;
    if (bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_use_release: got %0b expected 0", bus.stall); end
    nCompared++;
    if (sel1 !== 2'd2) begin nMismatched++; $display("[TB] FAIL load_use_sel_fwd: got %0d expected 2", sel1); end
    drain();
  endtask

  task automatic test_back_to_back();
    driveIssue(1'b1, 5'd5, 2'd0);
    tick();
    driveIssue(1'b1, 5'd5, 2'd0);
    tick();
    driveConsumer(2'b01, 5'd5, 5'd0);
    #1;
    nCompared++;
    if (sel0 !== 2'd1) begin nMismatched++; $display("[TB] FAIL b2b_youngest: got %0d expected 1", sel0); end
    drain();
    // Older ready rd=6 sits behind a younger rd=6 whose latency 3 caps to 2.
    driveIssue(1'b1, 5'd6, 2'd0);
    tick();
    driveIssue(1'b1, 5'd6, 2'd3);
    tick();
    driveConsumer(2'b01, 5'd6, 5'd0);
    #1;
    nCompared++;
    if (bus.stall !== 1'b1 || sel0 !== 2'd1) begin nMismatched++; $display("[TB] FAIL b2b_shadow_s0: got stall=%0b sel=%0d expected stall=1 sel=1", bus.stall, sel0); end
    tick();
    #1;
    nCompared++;
    if (bus.stall !== 1'b1 || sel0 !== 2'd2) begin nMismatched++; $display("[TB] FAIL b2b_shadow_s1: got stall=%0b sel=%0d expected stall=1 sel=2", bus.stall, sel0); end
    tick();
    #1;
    nCompared++;
    if (bus.stall !== 1'b0 || sel0 !== 2'd3) begin nMismatched++; $display("[TB] FAIL b2b_cap_ready: got stall=%0b sel=%0d expected stall=0 sel=3", bus.stall, sel0); end
    nCompared++;
    if (bus.stall_cnt !== 16'd3) begin nMismatched++; $display("[TB] FAIL b2b_cnt: got %0d expected 3", bus.stall_cnt); end
    drain();
  endtask

  task automatic test_no_match();
    driveIssue(1'b1, 5'd0, 2'd0);
    tick();
    driveConsumer(2'b01, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (sel0 !== 2'd0 || bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL r0_no_fwd: got sel=%0d stall=%0b expected sel=0 stall=0", sel0, bus.stall); end
    drain();
    driveIssue(1'b1, 5'd4, 2'd1);
    tick();
    driveConsumer(2'b00, 5'd4, 5'd4);
    #1;
    nCompared++;
    if (sel0 !== 2'd0) begin nMismatched++; $display("[TB] FAIL src_dis_sel0: got %0d expected 0", sel0); end
    nCompared++;
    if (sel1 !== 2'd0) begin nMismatched++; $display("[TB] FAIL src_dis_sel1: got %0d expected 0", sel1); end
    nCompared++;
    if (bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL src_dis_stall: got %0b expected 0", bus.stall); end
    drain();
  endtask

  task automatic test_flush();
    driveIssue(1'b1, 5'd7, 2'd1);
    tick();
    driveConsumer(2'b01, 5'd7, 5'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    nCompared++;
    if (bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_stall: got %0b expected 0", bus.stall); end
    nCompared++;
    if (sel0 !== 2'd0) begin nMismatched++; $display("[TB] FAIL flush_sel0: got %0d expected 0", sel0); end
    drain();
    driveIssue(1'b1, 5'd10, 2'd0);
    bus.flush = 1'b1;
    #1;
    nCompared++;
    if (bus.issue_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_issue_ready: got %0b expected 1", bus.issue_ready); end
    tick();
    driveConsumer(2'b01, 5'd10, 5'd0);
    #1;
    nCompared++;
    if (sel0 !== 2'd0) begin nMismatched++; $display("[TB] FAIL flush_wins: got %0d expected 0", sel0); end
    drain();
    driveIssue(1'b1, 5'd11, 2'd0);
    tick();
    driveIssue(1'b1, 5'd12, 2'd0);
    tick();
    setIdle();
    bus.flush = 1'b1;
    tick();
    driveConsumer(2'b11, 5'd11, 5'd12);
    #1;
    nCompared++;
    if (sel0 !== 2'd3) begin nMismatched++; $display("[TB] FAIL flush_older_kept: got %0d expected 3", sel0); end
    nCompared++;
    if (sel1 !== 2'd0 || bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_stage0_killed: got sel=%0d stall=%0b expected sel=0 stall=0", sel1, bus.stall); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    driveIssue(1'b1, 5'd9, 2'd2);
    tick();
    driveConsumer(2'b01, 5'd9, 5'd0);
    #1;
    nCompared++;
    if (bus.stall !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_pre_stall: got %0b expected 1", bus.stall); end
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_async_stall: got %0b expected 0", bus.stall); end
    nCompared++;
    if (bus.stall_cnt !== 16'd0) begin nMismatched++; $display("[TB] FAIL rst_async_cnt: got %0d expected 0", bus.stall_cnt); end
    nCompared++;
    if (sel0 !== 2'd0) begin nMismatched++; $display("[TB] FAIL rst_async_sel0: got %0d expected 0", sel0); end
    tick();
    rst_n = 1'b1;
    #1;
    nCompared++;
    if (sel0 !== 2'd0 || bus.stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_no_residual: got sel=%0d stall=%0b expected sel=0 stall=0", sel0, bus.stall); end
    drain();
  endtask

  initial begin
    setIdle();
    test_reset();
    test_lat0();
    test_load_use();
    test_back_to_back();
    test_no_match();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
